// File: rtl/pcs_sync.sv
// 1000BASE-X PCS receive synchronization FSM (comma detect / acquire sync / sync acquired levels).
// Consumes one classified code group per cg_valid strobe; all outputs are registered.
module pcs_sync #(
  parameter int GOOD_CGS = 4
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       cg_valid,
  input  logic       cg_comma,
  input  logic       cg_invalid,
  output logic       sync_status,
  output logic       rx_even,
  output logic [3:0] state,
  output logic [7:0] loss_count,
  output logic       sync_lost
);

  // state | meaning
  // LOSS  | loss of sync, hunting for a comma
  // CD1-3 | comma detected, expecting a /D/
  // AS1-2 | acquiring sync, expecting the next even comma
  // SA1   | sync acquired, no outstanding bad groups
  // SA2-4 | sync acquired, 1-3 bad levels outstanding
  typedef enum logic [3:0] {
    LOSS = 4'd0,
    CD1  = 4'd1,
    CD2  = 4'd2,
    CD3  = 4'd3,
    AS1  = 4'd4,
    AS2  = 4'd5,
    SA1  = 4'd8,
    SA2  = 4'd9,
    SA3  = 4'd10,
    SA4  = 4'd11
  } state_t;

  localparam logic [3:0] GOOD_LIM = GOOD_CGS[3:0];

  state_t     state_q, state_d;
  logic       rx_even_q, rx_even_d;
  logic [3:0] good_cnt_q, good_cnt_d;
  logic [7:0] loss_count_q, loss_count_d;
  logic       sync_lost_q, sync_lost_d;

  logic       cg_bad;
  logic       cg_data;
  logic [3:0] good_cnt_inc;

  assign cg_bad       = cg_invalid | (cg_comma & rx_even_q);
  assign cg_data      = ~cg_invalid & ~cg_comma;
  assign good_cnt_inc = good_cnt_q + 4'd1;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q      <= LOSS;
      rx_even_q    <= 1'b0;
      good_cnt_q   <= 4'd0;
      loss_count_q <= 8'd0;
      sync_lost_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      rx_even_q    <= rx_even_d;
      good_cnt_q   <= good_cnt_d;
      loss_count_q <= loss_count_d;
      sync_lost_q  <= sync_lost_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    rx_even_d    = rx_even_q;
    good_cnt_d   = good_cnt_q;
    loss_count_d = loss_count_q;
    sync_lost_d  = 1'b0;

    if (cg_valid) begin
      rx_even_d  = ~rx_even_q;
      good_cnt_d = 4'd0;
      case (state_q)
        LOSS: begin
          if (cg_comma && !cg_invalid) begin
            state_d   = CD1;
            rx_even_d = 1'b1;
          end
        end
        CD1: state_d = cg_data ? AS1 : LOSS;
        CD2: state_d = cg_data ? AS2 : LOSS;
        CD3: state_d = cg_data ? SA1 : LOSS;
        AS1, AS2: begin
          if (cg_bad) begin
            state_d = LOSS;
          end else if (cg_comma) begin
            state_d   = (state_q == AS1) ? CD2 : CD3;
            rx_even_d = 1'b1;
          end
        end
        SA1: begin
          if (cg_bad) state_d = SA2;
        end
        SA2, SA3, SA4: begin
          if (cg_bad) begin
            case (state_q)
              SA2:     state_d = SA3;
              SA3:     state_d = SA4;
              default: state_d = LOSS;
            endcase
          end else if (good_cnt_inc == GOOD_LIM) begin
            case (state_q)
              SA2:     state_d = SA1;
              SA3:     state_d = SA2;
              default: state_d = SA3;
            endcase
          end else begin
            good_cnt_d = good_cnt_inc;
          end
        end
        default: state_d = LOSS;
      endcase

      // Only SA4 can fall back to LOSS from the sync-acquired levels.
      if (state_q == SA4 && state_d == LOSS) begin
        sync_lost_d = 1'b1;
        if (loss_count_q != 8'hFF) loss_count_d = loss_count_q + 8'd1;
      end
    end
  end

  always_comb begin
    sync_status = (state_q == SA1) || (state_q == SA2) ||
                  (state_q == SA3) || (state_q == SA4);
    rx_even     = rx_even_q;
    state       = state_q;
    loss_count  = loss_count_q;
    sync_lost   = sync_lost_q;
  end

endmodule

// File: tb/tb_pcs_sync.sv
// Scoreboard bench for pcs_sync: a driver updates a level-based reference model and queues the
// expected outputs per cycle; a monitor compares them against the DUT just after each edge.
module tb_pcs_sync;

  localparam int GOOD = 4;

  logic       clk = 1'b0;
  logic       resetn = 1'b0;
  logic       cg_valid = 1'b0;
  logic       cg_comma = 1'b0;
  logic       cg_invalid = 1'b0;
  logic       sync_status;
  logic       rx_even;
  logic [3:0] state;
  logic [7:0] loss_count;
  logic       sync_lost;

  pcs_sync #(.GOOD_CGS(GOOD)) dut (
    .clk         (clk),
    .resetn      (resetn),
    .cg_valid    (cg_valid),
    .cg_comma    (cg_comma),
    .cg_invalid  (cg_invalid),
    .sync_status (sync_status),
    .rx_even     (rx_even),
    .state       (state),
    .loss_count  (loss_count),
    .sync_lost   (sync_lost)
  );

  always #4 clk = ~clk;

  typedef struct packed {
    logic [3:0] st;
    logic       ss;
    logic       ev;
    logic [7:0] lc;
    logic       sl;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   cyc = 0;

  // Reference model: acquisition phase 0..5 (LOSS, CD1-3, AS1-2) or a sync level 1..4.
  bit m_sync;
  int m_acq;
  int m_level;
  int m_good;
  int m_loss;
  bit m_even;
  bit m_lost;

  function automatic exp_t model_out();
    exp_t e;
    e.st = m_sync ? 4'(7 + m_level) : 4'(m_acq);
    e.ss = m_sync;
    e.ev = m_even;
    e.lc = 8'(m_loss);
    e.sl = m_lost;
    return e;
  endfunction

  task automatic model_reset();
    m_sync = 0; m_acq = 0; m_level = 1; m_good = 0; m_loss = 0; m_even = 0; m_lost = 0;
  endtask

  task automatic model_step(input bit comma, input bit inv);
    bit bad, dat, nxt_even;
    bad      = inv || (comma && m_even);
    dat      = !inv && !comma;
    nxt_even = !m_even;
    m_lost   = 0;
    if (m_sync) begin
      if (bad) begin
        m_good = 0;
        if (m_level == 4) begin
          m_sync = 0; m_acq = 0; m_lost = 1;
          if (m_loss < 255) m_loss++;
        end else m_level++;
      end else if (m_level > 1) begin
        m_good++;
        if (m_good == GOOD) begin m_level--; m_good = 0; end
      end
    end else if (m_acq == 0) begin
      if (comma && !inv) begin m_acq = 1; nxt_even = 1; end
    end else if (m_acq <= 3) begin
      if (!dat) m_acq = 0;
      else if (m_acq == 3) begin m_sync = 1; m_level = 1; m_good = 0; end
      else m_acq = m_acq + 3;
    end else begin
      if (bad) m_acq = 0;
      else if (comma) begin m_acq = m_acq - 2; nxt_even = 1; end
    end
    m_even = nxt_even;
  endtask

  task automatic send(input bit comma, input bit inv);
    @(negedge clk);
    resetn = 1'b1; cg_valid = 1'b1; cg_comma = comma; cg_invalid = inv;
    model_step(comma, inv);
    exp_q.push_back(model_out());
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      resetn = 1'b1; cg_valid = 1'b0;
      cg_comma = 1'($urandom); cg_invalid = 1'($urandom);
      m_lost = 0;
      exp_q.push_back(model_out());
    end
  endtask

  task automatic do_reset(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      resetn = 1'b0; cg_valid = 1'($urandom);
      cg_comma = 1'($urandom); cg_invalid = 1'($urandom);
      model_reset();
      exp_q.push_back(model_out());
    end
  endtask

  task automatic acquire(input int max_gap);
    for (int i = 0; i < 6; i++) begin
      send((i % 2) == 0, 1'b0);
      if (max_gap > 0) idle($urandom_range(max_gap, 0));
    end
  endtask

  // Monitor: every cycle has an expected entry, compared 1 time unit after the edge.
  initial begin
    exp_t e, a;
    forever begin
      @(posedge clk);
      #1;
      cyc++;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        a = '{st: state, ss: sync_status, ev: rx_even, lc: loss_count, sl: sync_lost};
        n_cmp++;
        if (a !== e) begin
          n_bad++;
          $display("FAIL outputs cycle %0d: got state=%0d sync=%0b even=%0b loss=%0d lost=%0b, want state=%0d sync=%0b even=%0b loss=%0d lost=%0b",
                   cyc, a.st, a.ss, a.ev, a.lc, a.sl, e.st, e.ss, e.ev, e.lc, e.sl);
        end
      end
    end
  end

  initial begin
    int r;
    model_reset();
    do_reset(2);

    acquire(0);                              // 1,4,2,5,3,8
    for (int i = 0; i < 4; i++) send(1'b0, 1'b1);  // 9,10,11,0 with sync_lost

    send(1'b1, 1'b0); send(1'b0, 1'b0); send(1'b0, 1'b0); send(1'b1, 1'b0);  // odd comma

    do_reset(1);
    acquire(0);
    send(1'b0, 1'b1);
    for (int i = 0; i < 4; i++) send(1'b0, 1'b0);  // back to SA1
    send(1'b0, 1'b1);
    for (int i = 0; i < 3; i++) send(1'b0, 1'b0);
    send(1'b0, 1'b1);                        // SA3, counter cleared
    send(1'b1, 1'b1);                        // comma+invalid is bad -> SA4

    do_reset(1);
    acquire(5);                              // gaps
    idle(3);

    do_reset(1);
    for (int i = 0; i < 4; i++) send((i % 2) == 0, 1'b0);  // reach AS2
    do_reset(1);
    send(1'b1, 1'b0);

    do_reset(1);
    for (int k = 0; k < 258; k++) begin      // saturation of loss_count
      acquire(0);
      for (int i = 0; i < 4; i++) send(1'b0, 1'b1);
    end

    for (int i = 0; i < 3000; i++) begin     // random traffic
      r = $urandom_range(99, 0);
      if (r < 2) do_reset(1);
      else if (r < 12) idle($urandom_range(3, 1));
      else if (r < 50) send(1'b0, 1'b0);
      else if (r < 80) send(1'b1, 1'b0);
      else if (r < 93) send(1'b0, 1'b1);
      else send(1'b1, 1'b1);
    end

    idle(1);
    repeat (3) @(posedge clk);
    #2;
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL drain: %0d entries left, want 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
